unsigned_sequential_divider: RTL and testbench
==============================================

Name: unsigned_sequential_divider

Overview:
- Iterative restoring divider for unsigned integers; the inverse operation to the team's combinational unsigned array multiplier.
- Computes quotient and remainder of a DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits in the arithmetic library beside the multipliers, for datapaths that can tolerate multi-cycle latency in exchange for small area.

Parameters:
DATA_WIDTH, 8, width of dividend, divisor, quotient and remainder (legal range 2..32)

Ports:
Clk_In  input  1  clock; all state updates on rising edge
Reset_N_In  input  1  asynchronous, active-low reset
Enable_In  input  1  clock enable; low freezes all state
Start_In  input  1  request a division; sampled only when idle or done
Dividend_In  input  DATA_WIDTH  unsigned dividend, sampled with accepted Start_In
Divisor_In  input  DATA_WIDTH  unsigned divisor, sampled with accepted Start_In
Busy_Out  output  1  operation in progress
Done_Out  output  1  one-cycle pulse: results valid
Quotient_Out  output  DATA_WIDTH  registered quotient, held until next accepted start
Remainder_Out  output  DATA_WIDTH  registered remainder, held until next accepted start
Div_By_Zero_Out  output  1  divisor was zero; valid with Done_Out, held with results

Behaviour:
- Reset (async assert, sync release) values:
  - FSM goes to IDLE.
  - Busy_Out=0, Done_Out=0.
  - Quotient_Out=0, Remainder_Out=0, Div_By_Zero_Out=0.
  - Iteration counter=0.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- FSM states are IDLE, CALC and DONE. DONE lasts exactly one cycle.
- Enable_In=0 in any state:
  - No state, counter or output register changes.
  - Start_In is ignored.
  - Done_Out holds its value. A stalled DONE stays DONE until Enable_In returns.
- Start acceptance: in IDLE or DONE, at a rising edge with Enable_In=1 and Start_In=1 ("edge 0"):
  - Latch the operands.
  - Clear the partial remainder.
  - Load the counter with DATA_WIDTH.
  - Go to CALC; Busy_Out=1.
- Back-to-back: a start accepted in DONE begins a new operation with no idle gap.
- Start_In while in CALC is ignored. Operands need only be valid at edge 0.
- CALC, one restoring step per enabled edge:
  - Shift {R,Q} left 1.
  - Trial = R_shifted - divisor, using a DATA_WIDTH+1-bit subtract to capture the borrow.
  - If no borrow: R = trial and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - Decrement the counter.
- After the final step (enabled edge W, W=DATA_WIDTH):
  - Register Quotient_Out, Remainder_Out and Div_By_Zero_Out.
  - Busy_Out falls to 0; Done_Out rises to 1; go to DONE.
  - Next enabled edge: Done_Out falls to 0 and the FSM returns to IDLE, unless a new start is accepted.
- Latency: Done_Out is high in the cycle following the W-th enabled edge after the start edge. Busy_Out is high for exactly W enabled cycles.
- Divide by zero: the algorithm runs unmodified and yields Quotient = all ones and Remainder = dividend. Div_By_Zero_Out=1.
- Result invariant for every nonzero divisor: Dividend = Q*D + R, with R < D.

Optional Feature:
Macro: UNSIGNED_DIVIDER_EARLY_OUT_EN
- Defined: at start acceptance, if divisor == 0 or divisor > dividend, skip CALC.
  - Results are registered directly: Q = all ones for divisor 0, else Q = 0; R = dividend.
  - Busy_Out is high for one cycle; Done_Out pulses after enabled edge 1.
  - All other operands use the full W-cycle path.
- Undefined: every operation takes W cycles; results are identical.

Test Plan:
- W=8, 200/7 -> Quotient_Out=28, Remainder_Out=4, Div_By_Zero_Out=0; Done_Out pulses exactly one cycle, after the 8th edge after the start edge; Busy_Out high 8 cycles.
- 255/1 then back-to-back start (Start_In held high in DONE) with 13/0 -> first result 255 R 0; second result Quotient_Out=255, Remainder_Out=13, Div_By_Zero_Out=1; no idle cycle between operations.
- 5/9 -> Q=0, R=5; Done after 8 cycles with macro undefined, after 1 cycle with UNSIGNED_DIVIDER_EARLY_OUT_EN defined.
- Start 100/3, pulse Start_In with other operands (50/5) at cycle 3 of CALC, and drop Enable_In for 3 cycles mid-CALC -> result 33 R 1; Done delayed by exactly 3 cycles; the second start is ignored.
- Start 200/7, assert Reset_N_In at iteration 4 -> all outputs 0 asynchronously; after release, start 81/9 -> Q=9, R=0, no Done pulse from the aborted operation.
- Randomised sweep, 1000 operand pairs including 0 and 255 -> Q*D + R == dividend and R < D for D≠0.

Source files
------------

// File: rtl/unsigned_sequential_divider.sv
// unsigned_sequential_divider
// ---------------------------------------------------------------------------
// Iterative restoring divider for unsigned integers. It produces one quotient
// bit per enabled clock, so a full division takes DATA_WIDTH cycles.
//
// Handshake (valid/ready style): Start_In is accepted on a rising edge with
// Enable_In=1 while the FSM is IDLE or DONE. Busy_Out is high while the
// divider iterates. Done_Out pulses for one enabled cycle with the results.
// Start_In is ignored while busy. Operands only need to be valid on the
// accepting edge. Quotient/Remainder/Div_By_Zero are held until the next
// result overwrites them.
//
// Optional feature macro: UNSIGNED_DIVIDER_EARLY_OUT_EN
//   When defined, a divisor of zero or a divisor greater than the dividend
//   skips the iteration and finishes one cycle after the start.
//
// Ports:
//   Clk_In          clock, rising edge
//   Reset_N_In      asynchronous active-low reset
//   Enable_In       clock enable; low freezes every register
//   Start_In        division request
//   Dividend_In     unsigned dividend  [DATA_WIDTH]
//   Divisor_In      unsigned divisor   [DATA_WIDTH]
//   Busy_Out        operation in progress
//   Done_Out        one-cycle result-valid pulse
//   Quotient_Out    registered quotient  [DATA_WIDTH]
//   Remainder_Out   registered remainder [DATA_WIDTH]
//   Div_By_Zero_Out divisor was zero (valid with Done_Out, held)
//   State_Dbg_Out   FSM state for observation: 0=IDLE 1=CALC 2=DONE
module unsigned_sequential_divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Dividend_In,
  input  logic [DATA_WIDTH-1:0] Divisor_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Quotient_Out,
  output logic [DATA_WIDTH-1:0] Remainder_Out,
  output logic                  Div_By_Zero_Out,
  output logic [1:0]            State_Dbg_Out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] q_reg;   // dividend shifts out, quotient shifts in
  logic [DATA_WIDTH-1:0] r_reg;   // partial remainder
  logic [DATA_WIDTH-1:0] d_reg;   // latched divisor
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
  logic                  early_q; // current operation takes the short path
`endif

  // One restoring step. The partial remainder stays below the divisor, so the
  // shifted value fits in DATA_WIDTH+1 bits and bit DATA_WIDTH of the trial
  // difference is exactly the borrow.
  logic [DATA_WIDTH:0]   r_sh;
  logic [DATA_WIDTH:0]   trial;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] r_next;
  logic [DATA_WIDTH-1:0] q_next;

  always_comb begin
    r_sh   = {r_reg, q_reg[DATA_WIDTH-1]};
    trial  = r_sh - {1'b0, d_reg};
    borrow = trial[DATA_WIDTH];
    r_next = borrow ? r_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    q_next = {q_reg[DATA_WIDTH-2:0], ~borrow};
  end

  assign State_Dbg_Out = state;

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state           <= IDLE;
      cnt             <= '0;
      q_reg           <= '0;
      r_reg           <= '0;
      d_reg           <= '0;
      Busy_Out        <= 1'b0;
      Done_Out        <= 1'b0;
      Quotient_Out    <= '0;
      Remainder_Out   <= '0;
      Div_By_Zero_Out <= 1'b0;
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
      early_q         <= 1'b0;
`endif
    end else if (Enable_In) begin
      case (state)
        IDLE, DONE: begin
          Done_Out <= 1'b0;
          if (Start_In) begin
            q_reg    <= Dividend_In;
            d_reg    <= Divisor_In;
            r_reg    <= '0;
            cnt      <= CW'(DATA_WIDTH);
            Busy_Out <= 1'b1;
            state    <= CALC;
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
            early_q  <= (Divisor_In == '0) || (Divisor_In > Dividend_In);
`endif
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
          if (early_q) begin
            // q_reg still holds the untouched dividend here.
            Quotient_Out    <= (d_reg == '0) ? '1 : '0;
            Remainder_Out   <= q_reg;
            Div_By_Zero_Out <= (d_reg == '0);
            Busy_Out        <= 1'b0;
            Done_Out        <= 1'b1;
            cnt             <= '0;
            early_q         <= 1'b0;
            state           <= DONE;
          end else begin
`else
          begin
`endif
            q_reg <= q_next;
            r_reg <= r_next;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              Quotient_Out    <= q_next;
              Remainder_Out   <= r_next;
              Div_By_Zero_Out <= (d_reg == '0);
              Busy_Out        <= 1'b0;
              Done_Out        <= 1'b1;
              state           <= DONE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          Busy_Out <= 1'b0;
          Done_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_sequential_divider.sv
// Directed bench for unsigned_sequential_divider (DATA_WIDTH = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_unsigned_sequential_divider;

  localparam int W = 8;
`ifdef UNSIGNED_DIVIDER_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = W;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  unsigned_sequential_divider #(.DATA_WIDTH(W)) dut (
    .Clk_In          (clk),
    .Reset_N_In      (rst_n),
    .Enable_In       (enable),
    .Start_In        (start),
    .Dividend_In     (dividend),
    .Divisor_In      (divisor),
    .Busy_Out        (busy),
    .Done_Out        (done),
    .Quotient_Out    (quotient),
    .Remainder_Out   (remainder),
    .Div_By_Zero_Out (dbz),
    .State_Dbg_Out   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered and left just after a falling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Counts falling edges since the start edge until Done_Out is seen.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 1);
  endtask

  int cyc, bcnt;

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_q", {24'd0, quotient}, 0);
    chk("rst_r", {24'd0, remainder}, 0);
    chk("rst_dbz", {31'd0, dbz}, 0);
    chk("rst_state", {30'd0, state_dbg}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // ---------------- 200 / 7 ----------------
    start_op(8'd200, 8'd7, 1'b0);
    chk("t1_busy_after_start", {31'd0, busy}, 1);
    wait_done(cyc, bcnt);
    chk("t1_latency", cyc, W);
    chk("t1_busy_cycles", bcnt, W);
    chk("t1_busy_low", {31'd0, busy}, 0);
    chk("t1_q", {24'd0, quotient}, 28);
    chk("t1_r", {24'd0, remainder}, 4);
    chk("t1_dbz", {31'd0, dbz}, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done}, 0);
    chk("t1_state_idle", {30'd0, state_dbg}, 0);
    chk("t1_q_held", {24'd0, quotient}, 28);

    // ---------------- 255 / 1 then back-to-back 13 / 0 ----------------
    start_op(8'd255, 8'd1, 1'b1);
    wait_done(cyc, bcnt);
    chk("t2a_latency", cyc, W);
    chk("t2a_q", {24'd0, quotient}, 255);
    chk("t2a_r", {24'd0, remainder}, 0);
    chk("t2a_dbz", {31'd0, dbz}, 0);
    dividend = 8'd13;
    divisor  = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t2_no_gap_busy", {31'd0, busy}, 1);
    chk("t2_no_gap_done", {31'd0, done}, 0);
    chk("t2_no_gap_state", {30'd0, state_dbg}, 1);
    wait_done(cyc, bcnt);
    chk("t2b_latency", cyc, EARLY_LAT);
    chk("t2b_q", {24'd0, quotient}, 255);
    chk("t2b_r", {24'd0, remainder}, 13);
    chk("t2b_dbz", {31'd0, dbz}, 1);
    @(negedge clk);

    // ---------------- 5 / 9 ----------------
    start_op(8'd5, 8'd9, 1'b0);
    wait_done(cyc, bcnt);
    chk("t3_latency", cyc, EARLY_LAT);
    chk("t3_busy_cycles", bcnt, EARLY_LAT);
    chk("t3_q", {24'd0, quotient}, 0);
    chk("t3_r", {24'd0, remainder}, 5);
    chk("t3_dbz", {31'd0, dbz}, 0);
    @(negedge clk);

    // ---------------- 100 / 3 with ignored start and enable stall ----------------
    start_op(8'd100, 8'd3, 1'b0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (cyc == 2) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end
      if (cyc == 3) start = 1'b0;
      if (cyc == 4) enable = 1'b0;
      if (cyc == 7) enable = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("t4_done_seen", {31'd0, done}, 1);
    chk("t4_latency", cyc, W + 3);
    chk("t4_q", {24'd0, quotient}, 33);
    chk("t4_r", {24'd0, remainder}, 1);
    // A stalled DONE holds its pulse.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_done_stalled", {31'd0, done}, 1);
    chk("t4_state_stalled", {30'd0, state_dbg}, 2);
    enable = 1'b1;
    @(negedge clk);
    chk("t4_done_released", {31'd0, done}, 0);

    // ---------------- reset mid-operation, then 81 / 9 ----------------
    start_op(8'd200, 8'd7, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_done", {31'd0, done}, 0);
    chk("t5_rst_q", {24'd0, quotient}, 0);
    chk("t5_rst_r", {24'd0, remainder}, 0);
    chk("t5_rst_dbz", {31'd0, dbz}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_stale_done", {31'd0, done}, 0);
    start_op(8'd81, 8'd9, 1'b0);
    wait_done(cyc, bcnt);
    chk("t5_latency", cyc, W);
    chk("t5_q", {24'd0, quotient}, 9);
    chk("t5_r", {24'd0, remainder}, 0);
    @(negedge clk);

    // ---------------- operand sweep ----------------
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (i % 10 == 0) a = 8'd255;
      if (i % 10 == 1) a = 8'd0;
      if (i % 10 == 2) b = 8'd255;
      if (i % 10 == 3) b = 8'd0;
      if (i % 10 == 4) b = 8'd1;
      start_op(a, b, 1'b0);
      wait_done(cyc, bcnt);
      if (b != 0) begin
        chk("sweep_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("sweep_r_lt_d", {31'd0, remainder < b}, 1);
        chk("sweep_dbz0", {31'd0, dbz}, 0);
      end else begin
        chk("sweep_q_ones", {24'd0, quotient}, 255);
        chk("sweep_r_div0", {24'd0, remainder}, {24'd0, a});
        chk("sweep_dbz1", {31'd0, dbz}, 1);
      end
      @(negedge clk);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
